score_tracker_multi: RTL and testbench

Parametrised successor to the single-player scorer: tracks score, combo, multiplier and best combo for NUM_PLAYERS independent players fed by graded hit inputs (perfect/good/miss). Each player's hit inputs are edge-detected internally; points are weighted by grade and by a combo-driven multiplier. A session high score and a leader index are maintained for the display and VGA overlay logic.

---
 rtl/score_tracker_multi_if.sv | 29 ++
 rtl/score_tracker_multi.sv | 206 ++++++++++++++++++++
 tb/tb_score_tracker_multi.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/score_tracker_multi_if.sv
// Bundle of game-control, hit and score-display signals exchanged between
// the game front end (master) and the multi-player scorer (slave).
interface score_tracker_multi_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = 14,
    parameter int COMBO_W     = 14
);
    logic                           game_active;
    logic                           clear;
    logic [NUM_PLAYERS-1:0]         hit_perfect;
    logic [NUM_PLAYERS-1:0]         hit_good;
    logic [NUM_PLAYERS-1:0]         hit_miss;
    logic [NUM_PLAYERS*SCORE_W-1:0] score;
    logic [NUM_PLAYERS*COMBO_W-1:0] combo;
    logic [NUM_PLAYERS*COMBO_W-1:0] max_combo;
    logic [NUM_PLAYERS*4-1:0]       multiplier;
    logic [SCORE_W-1:0]             high_score;
    logic [1:0]                     leader;

    modport master (
        output game_active, clear, hit_perfect, hit_good, hit_miss,
        input  score, combo, max_combo, multiplier, high_score, leader
    );

    modport slave (
        input  game_active, clear, hit_perfect, hit_good, hit_miss,
        output score, combo, max_combo, multiplier, high_score, leader
    );
endinterface

// File: rtl/score_tracker_multi.sv
// Multi-player score tracker: per-player score, combo, best combo and
// combo-driven multiplier, plus a session high score and a leader index.
// Hit levels are asynchronous; each is synchronised and edge-detected so a
// held level yields exactly one event.
module score_tracker_multi #(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = 14,
    parameter int COMBO_W     = 14,
    parameter int PERFECT_PTS = 2,
    parameter int GOOD_PTS    = 1,
    parameter int T_X2        = 4,
    parameter int T_X4        = 10,
    parameter int T_X8        = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    score_tracker_multi_if.slave  bus
);
    localparam int NP    = NUM_PLAYERS;
    localparam int SUM_W = SCORE_W + 8;   // headroom for base * 8 before clamping

    localparam logic [SUM_W-1:0]   SCORE_MAX_C = {8'd0, {SCORE_W{1'b1}}};
    localparam logic [COMBO_W-1:0] COMBO_MAX_C = {COMBO_W{1'b1}};
    localparam logic [COMBO_W-1:0] T_X2_C      = COMBO_W'(T_X2);
    localparam logic [COMBO_W-1:0] T_X4_C      = COMBO_W'(T_X4);
    localparam logic [COMBO_W-1:0] T_X8_C      = COMBO_W'(T_X8);
    localparam logic [SUM_W-1:0]   PERF_C      = SUM_W'(PERFECT_PTS);
    localparam logic [SUM_W-1:0]   GOOD_C      = SUM_W'(GOOD_PTS);

    // Event vectors are packed as {miss, good, perfect}, NP bits each
    logic [3*NP-1:0] raw_s;
    logic [3*NP-1:0] sync1_r;
    logic [3*NP-1:0] sync2_r;
    logic [3*NP-1:0] edge_r;
    logic [3*NP-1:0] evt_r;

    logic [SCORE_W-1:0] score_r    [NP];
    logic [SCORE_W-1:0] score_nx_s [NP];
    logic [COMBO_W-1:0] combo_r    [NP];
    logic [COMBO_W-1:0] combo_nx_s [NP];
    logic [COMBO_W-1:0] max_r      [NP];
    logic [COMBO_W-1:0] max_nx_s   [NP];
    logic [3:0]         mult_r     [NP];
    logic [3:0]         mult_nx_s  [NP];
    logic [1:0]         shift_s    [NP];
    logic [SUM_W-1:0]   sum_s      [NP];
    logic [COMBO_W-1:0] inc_s      [NP];

    logic [SCORE_W-1:0] best_s;
    logic [1:0]         lead_s;
    logic [SCORE_W-1:0] high_r;
    logic [1:0]         leader_r;
    logic               ga_prev_r;

    logic [NP*SCORE_W-1:0] score_flat_s;
    logic [NP*COMBO_W-1:0] combo_flat_s;
    logic [NP*COMBO_W-1:0] max_flat_s;
    logic [NP*4-1:0]       mult_flat_s;

    assign raw_s = {bus.hit_miss, bus.hit_good, bus.hit_perfect};

    // Two-flop synchroniser followed by a registered rising-edge detector
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= {(3*NP){1'b0}};
            sync2_r <= {(3*NP){1'b0}};
            edge_r  <= {(3*NP){1'b0}};
            evt_r   <= {(3*NP){1'b0}};
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            edge_r  <= sync2_r;
            evt_r   <= sync2_r & ~edge_r;
        end
    end

    // Per-player next state: clear beats miss, miss beats perfect beats good
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            score_nx_s[i] = score_r[i];
            combo_nx_s[i] = combo_r[i];
            max_nx_s[i]   = max_r[i];
            mult_nx_s[i]  = mult_r[i];

            // Multiplier tier is chosen from the combo before this hit
            if (combo_r[i] >= T_X8_C) begin
                shift_s[i] = 2'd3;
            end else if (combo_r[i] >= T_X4_C) begin
                shift_s[i] = 2'd2;
            end else if (combo_r[i] >= T_X2_C) begin
                shift_s[i] = 2'd1;
            end else begin
                shift_s[i] = 2'd0;
            end

            if (combo_r[i] == COMBO_MAX_C) begin
                inc_s[i] = combo_r[i];
            end else begin
                inc_s[i] = combo_r[i] + 1'b1;
            end

            // Perfect wins over good when both arrive together
            if (evt_r[i]) begin
                sum_s[i] = {8'd0, score_r[i]} + (PERF_C << shift_s[i]);
            end else begin
                sum_s[i] = {8'd0, score_r[i]} + (GOOD_C << shift_s[i]);
            end

            if (bus.clear) begin
                score_nx_s[i] = {SCORE_W{1'b0}};
                combo_nx_s[i] = {COMBO_W{1'b0}};
                max_nx_s[i]   = {COMBO_W{1'b0}};
                mult_nx_s[i]  = 4'd1;
            end else if (bus.game_active && evt_r[2*NP+i]) begin
                combo_nx_s[i] = {COMBO_W{1'b0}};
                mult_nx_s[i]  = 4'd1;
            end else if (bus.game_active && (evt_r[i] || evt_r[NP+i])) begin
                if (sum_s[i] > SCORE_MAX_C) begin
                    score_nx_s[i] = {SCORE_W{1'b1}};
                end else begin
                    score_nx_s[i] = sum_s[i][SCORE_W-1:0];
                end
                combo_nx_s[i] = inc_s[i];
                if (inc_s[i] > max_r[i]) begin
                    max_nx_s[i] = inc_s[i];
                end else begin
                    max_nx_s[i] = max_r[i];
                end
                mult_nx_s[i] = 4'd1 << shift_s[i];
            end else begin
                score_nx_s[i] = score_r[i];
                combo_nx_s[i] = combo_r[i];
            end
        end
    end

    // Per-player state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                score_r[i] <= {SCORE_W{1'b0}};
                combo_r[i] <= {COMBO_W{1'b0}};
                max_r[i]   <= {COMBO_W{1'b0}};
                mult_r[i]  <= 4'd1;
            end
        end else begin
            for (int i = 0; i < NP; i++) begin
                score_r[i] <= score_nx_s[i];
                combo_r[i] <= combo_nx_s[i];
                max_r[i]   <= max_nx_s[i];
                mult_r[i]  <= mult_nx_s[i];
            end
        end
    end

    // Best current score and its owner; ties keep the lowest index
    always_comb begin
        best_s = score_r[0];
        lead_s = 2'd0;
        for (int i = 1; i < NP; i++) begin
            if (score_r[i] > best_s) begin
                best_s = score_r[i];
                lead_s = 2'(i);
            end else begin
                best_s = best_s;
                lead_s = lead_s;
            end
        end
    end

    // Leader tracks scores every cycle; high score latches when a game ends
    always_ff @(posedge clk) begin
        if (rst) begin
            high_r    <= {SCORE_W{1'b0}};
            leader_r  <= 2'd0;
            ga_prev_r <= 1'b0;
        end else begin
            ga_prev_r <= bus.game_active;
            leader_r  <= lead_s;
            if (ga_prev_r && !bus.game_active && (best_s > high_r)) begin
                high_r <= best_s;
            end
        end
    end

    // Flatten per-player registers onto the display buses
    always_comb begin
        score_flat_s = {(NP*SCORE_W){1'b0}};
        combo_flat_s = {(NP*COMBO_W){1'b0}};
        max_flat_s   = {(NP*COMBO_W){1'b0}};
        mult_flat_s  = {(NP*4){1'b0}};
        for (int i = 0; i < NP; i++) begin
            score_flat_s[i*SCORE_W +: SCORE_W] = score_r[i];
            combo_flat_s[i*COMBO_W +: COMBO_W] = combo_r[i];
            max_flat_s[i*COMBO_W +: COMBO_W]   = max_r[i];
            mult_flat_s[i*4 +: 4]              = mult_r[i];
        end
    end

    assign bus.score      = score_flat_s;
    assign bus.combo      = combo_flat_s;
    assign bus.max_combo  = max_flat_s;
    assign bus.multiplier = mult_flat_s;
    assign bus.high_score = high_r;
    assign bus.leader     = leader_r;
endmodule

// File: tb/tb_score_tracker_multi.sv
// Directed bench for score_tracker_multi: a default two-player instance and a
// narrow-score (SCORE_W=6) instance for saturation. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_score_tracker_multi;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    score_tracker_multi_if #(.NUM_PLAYERS(2), .SCORE_W(14), .COMBO_W(14)) bus ();
    score_tracker_multi_if #(.NUM_PLAYERS(2), .SCORE_W(6),  .COMBO_W(14)) sbus ();

    score_tracker_multi #(
        .NUM_PLAYERS(2), .SCORE_W(14), .COMBO_W(14), .PERFECT_PTS(2), .GOOD_PTS(1),
        .T_X2(4), .T_X4(10), .T_X8(15)
    ) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    score_tracker_multi #(
        .NUM_PLAYERS(2), .SCORE_W(6), .COMBO_W(14), .PERFECT_PTS(2), .GOOD_PTS(1),
        .T_X2(4), .T_X4(10), .T_X8(15)
    ) dut_s (.clk(clk), .rst(rst), .bus(sbus.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sc(input int p);
        return int'(bus.score[p*14 +: 14]);
    endfunction
    function automatic int cb(input int p);
        return int'(bus.combo[p*14 +: 14]);
    endfunction
    function automatic int mx(input int p);
        return int'(bus.max_combo[p*14 +: 14]);
    endfunction
    function automatic int ml(input int p);
        return int'(bus.multiplier[p*4 +: 4]);
    endfunction

    task automatic hit(input int kind, input logic [1:0] mask, input int hi, input int lo);
        case (kind)
            0:       bus.hit_perfect = mask;
            1:       bus.hit_good    = mask;
            default: bus.hit_miss    = mask;
        endcase
        repeat (hi) @(negedge clk);
        bus.hit_perfect = 2'b00;
        bus.hit_good    = 2'b00;
        bus.hit_miss    = 2'b00;
        repeat (lo) @(negedge clk);
    endtask

    task automatic s_hit(input int hi, input int lo);
        sbus.hit_perfect = 2'b01;
        repeat (hi) @(negedge clk);
        sbus.hit_perfect = 2'b00;
        repeat (lo) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.score !== 28'd0) begin n_bad++; $display("FAIL rst_score: got %h expected 0", bus.score); end
        n_cmp++; if (bus.combo !== 28'd0) begin n_bad++; $display("FAIL rst_combo: got %h expected 0", bus.combo); end
        n_cmp++; if (bus.max_combo !== 28'd0) begin n_bad++; $display("FAIL rst_max: got %h expected 0", bus.max_combo); end
        n_cmp++; if (bus.multiplier !== 8'h11) begin n_bad++; $display("FAIL rst_mult: got %h expected 11", bus.multiplier); end
        n_cmp++; if (bus.high_score !== 14'd0) begin n_bad++; $display("FAIL rst_high: got %0d expected 0", bus.high_score); end
        n_cmp++; if (bus.leader !== 2'd0) begin n_bad++; $display("FAIL rst_leader: got %0d expected 0", bus.leader); end
        n_cmp++; if (sbus.score !== 12'd0) begin n_bad++; $display("FAIL rst_sscore: got %h expected 0", sbus.score); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_latency();
        int exp_s[5];
        int prev;
        exp_s = '{1, 2, 3, 4, 6};
        prev = 0;
        bus.game_active = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            bus.hit_good[0] = 1'b1;
            repeat (3) @(negedge clk);
            n_cmp++; if (sc(0) !== prev) begin n_bad++; $display("FAIL lat_early%0d: got %0d expected %0d", k, sc(0), prev); end
            @(negedge clk);
            n_cmp++; if (sc(0) !== exp_s[k]) begin n_bad++; $display("FAIL lat_step%0d: got %0d expected %0d", k, sc(0), exp_s[k]); end
            bus.hit_good[0] = 1'b0;
            repeat (4) @(negedge clk);
            prev = exp_s[k];
        end
        n_cmp++; if (cb(0) !== 5) begin n_bad++; $display("FAIL lat_combo0: got %0d expected 5", cb(0)); end
        n_cmp++; if (ml(0) !== 2) begin n_bad++; $display("FAIL lat_mult0: got %0d expected 2", ml(0)); end
        n_cmp++; if (mx(0) !== 5) begin n_bad++; $display("FAIL lat_max0: got %0d expected 5", mx(0)); end
        n_cmp++; if (sc(1) !== 0) begin n_bad++; $display("FAIL lat_score1: got %0d expected 0", sc(1)); end
    endtask

    task automatic test_multiplier();
        repeat (15) hit(0, 2'b10, 4, 4);
        n_cmp++; if (sc(1) !== 72) begin n_bad++; $display("FAIL mul_score15: got %0d expected 72", sc(1)); end
        n_cmp++; if (cb(1) !== 15) begin n_bad++; $display("FAIL mul_combo15: got %0d expected 15", cb(1)); end
        n_cmp++; if (ml(1) !== 4) begin n_bad++; $display("FAIL mul_mult15: got %0d expected 4", ml(1)); end
        hit(0, 2'b10, 4, 4);
        n_cmp++; if (sc(1) !== 88) begin n_bad++; $display("FAIL mul_score16: got %0d expected 88", sc(1)); end
        n_cmp++; if (ml(1) !== 8) begin n_bad++; $display("FAIL mul_mult16: got %0d expected 8", ml(1)); end
        n_cmp++; if (cb(1) !== 16) begin n_bad++; $display("FAIL mul_combo16: got %0d expected 16", cb(1)); end
        n_cmp++; if (bus.leader !== 2'd1) begin n_bad++; $display("FAIL mul_leader: got %0d expected 1", bus.leader); end
        hit(2, 2'b10, 4, 4);
        n_cmp++; if (cb(1) !== 0) begin n_bad++; $display("FAIL miss_combo1: got %0d expected 0", cb(1)); end
        n_cmp++; if (ml(1) !== 1) begin n_bad++; $display("FAIL miss_mult1: got %0d expected 1", ml(1)); end
        n_cmp++; if (mx(1) !== 16) begin n_bad++; $display("FAIL miss_max1: got %0d expected 16", mx(1)); end
        n_cmp++; if (sc(1) !== 88) begin n_bad++; $display("FAIL miss_score1: got %0d expected 88", sc(1)); end
    endtask

    task automatic test_priority();
        bus.hit_perfect = 2'b01;
        bus.hit_miss    = 2'b01;
        bus.hit_good    = 2'b10;
        repeat (4) @(negedge clk);
        bus.hit_perfect = 2'b00;
        bus.hit_miss    = 2'b00;
        bus.hit_good    = 2'b00;
        repeat (4) @(negedge clk);
        n_cmp++; if (sc(0) !== 6) begin n_bad++; $display("FAIL pri_score0: got %0d expected 6", sc(0)); end
        n_cmp++; if (cb(0) !== 0) begin n_bad++; $display("FAIL pri_combo0: got %0d expected 0", cb(0)); end
        n_cmp++; if (ml(0) !== 1) begin n_bad++; $display("FAIL pri_mult0: got %0d expected 1", ml(0)); end
        n_cmp++; if (mx(0) !== 5) begin n_bad++; $display("FAIL pri_max0: got %0d expected 5", mx(0)); end
        n_cmp++; if (sc(1) !== 89) begin n_bad++; $display("FAIL pri_score1: got %0d expected 89", sc(1)); end
        n_cmp++; if (cb(1) !== 1) begin n_bad++; $display("FAIL pri_combo1: got %0d expected 1", cb(1)); end
    endtask

    task automatic test_inactive();
        bus.game_active = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.high_score !== 14'd89) begin n_bad++; $display("FAIL ina_high_fall: got %0d expected 89", bus.high_score); end
        hit(0, 2'b11, 4, 4);
        hit(1, 2'b11, 4, 4);
        n_cmp++; if (sc(0) !== 6) begin n_bad++; $display("FAIL ina_score0: got %0d expected 6", sc(0)); end
        n_cmp++; if (sc(1) !== 89) begin n_bad++; $display("FAIL ina_score1: got %0d expected 89", sc(1)); end
        n_cmp++; if (cb(0) !== 0) begin n_bad++; $display("FAIL ina_combo0: got %0d expected 0", cb(0)); end
        n_cmp++; if (cb(1) !== 1) begin n_bad++; $display("FAIL ina_combo1: got %0d expected 1", cb(1)); end
        n_cmp++; if (bus.high_score !== 14'd89) begin n_bad++; $display("FAIL ina_high_hold: got %0d expected 89", bus.high_score); end
    endtask

    task automatic test_saturation();
        sbus.game_active = 1'b1;
        @(negedge clk);
        repeat (13) s_hit(4, 4);
        n_cmp++; if (sbus.score[5:0] !== 6'd56) begin n_bad++; $display("FAIL sat_56: got %0d expected 56", sbus.score[5:0]); end
        s_hit(4, 4);
        n_cmp++; if (sbus.score[5:0] !== 6'd63) begin n_bad++; $display("FAIL sat_clamp: got %0d expected 63", sbus.score[5:0]); end
        s_hit(4, 4);
        n_cmp++; if (sbus.score[5:0] !== 6'd63) begin n_bad++; $display("FAIL sat_hold: got %0d expected 63", sbus.score[5:0]); end
        n_cmp++; if (sbus.combo[13:0] !== 14'd15) begin n_bad++; $display("FAIL sat_combo15: got %0d expected 15", sbus.combo[13:0]); end
        s_hit(20, 4);
        n_cmp++; if (sbus.combo[13:0] !== 14'd16) begin n_bad++; $display("FAIL held_once: got %0d expected 16", sbus.combo[13:0]); end
        n_cmp++; if (sbus.score[5:0] !== 6'd63) begin n_bad++; $display("FAIL held_score: got %0d expected 63", sbus.score[5:0]); end
        sbus.game_active = 1'b0;
    endtask

    task automatic test_tie_high();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.game_active = 1'b1;
        @(negedge clk);
        repeat (11) hit(0, 2'b11, 4, 4);
        n_cmp++; if (sc(0) !== 40) begin n_bad++; $display("FAIL tie_score0: got %0d expected 40", sc(0)); end
        n_cmp++; if (sc(1) !== 40) begin n_bad++; $display("FAIL tie_score1: got %0d expected 40", sc(1)); end
        n_cmp++; if (bus.leader !== 2'd0) begin n_bad++; $display("FAIL tie_leader: got %0d expected 0", bus.leader); end
        n_cmp++; if (bus.high_score !== 14'd0) begin n_bad++; $display("FAIL tie_high_ingame: got %0d expected 0", bus.high_score); end
        bus.game_active = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.high_score !== 14'd40) begin n_bad++; $display("FAIL tie_high: got %0d expected 40", bus.high_score); end
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        n_cmp++; if (bus.score !== 28'd0) begin n_bad++; $display("FAIL clr_score: got %h expected 0", bus.score); end
        n_cmp++; if (bus.combo !== 28'd0) begin n_bad++; $display("FAIL clr_combo: got %h expected 0", bus.combo); end
        n_cmp++; if (bus.max_combo !== 28'd0) begin n_bad++; $display("FAIL clr_max: got %h expected 0", bus.max_combo); end
        n_cmp++; if (bus.multiplier !== 8'h11) begin n_bad++; $display("FAIL clr_mult: got %h expected 11", bus.multiplier); end
        n_cmp++; if (bus.high_score !== 14'd40) begin n_bad++; $display("FAIL clr_high: got %0d expected 40", bus.high_score); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (bus.high_score !== 14'd0) begin n_bad++; $display("FAIL rst_high2: got %0d expected 0", bus.high_score); end
    endtask

    task automatic test_rst_mid();
        bus.game_active = 1'b1;
        @(negedge clk);
        repeat (3) hit(1, 2'b01, 4, 4);
        n_cmp++; if (cb(0) !== 3) begin n_bad++; $display("FAIL mid_combo: got %0d expected 3", cb(0)); end
        n_cmp++; if (sc(0) !== 3) begin n_bad++; $display("FAIL mid_score: got %0d expected 3", sc(0)); end
        bus.hit_perfect = 2'b01;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.score !== 28'd0) begin n_bad++; $display("FAIL mid_rst_score: got %h expected 0", bus.score); end
        n_cmp++; if (bus.combo !== 28'd0) begin n_bad++; $display("FAIL mid_rst_combo: got %h expected 0", bus.combo); end
        n_cmp++; if (bus.max_combo !== 28'd0) begin n_bad++; $display("FAIL mid_rst_max: got %h expected 0", bus.max_combo); end
        n_cmp++; if (bus.multiplier !== 8'h11) begin n_bad++; $display("FAIL mid_rst_mult: got %h expected 11", bus.multiplier); end
        rst = 1'b0;
        bus.hit_perfect = 2'b00;
        bus.game_active = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.game_active  = 1'b0;
        bus.clear        = 1'b0;
        bus.hit_perfect  = 2'b00;
        bus.hit_good     = 2'b00;
        bus.hit_miss     = 2'b00;
        sbus.game_active = 1'b0;
        sbus.clear       = 1'b0;
        sbus.hit_perfect = 2'b00;
        sbus.hit_good    = 2'b00;
        sbus.hit_miss    = 2'b00;
        @(negedge clk);
        test_reset();
        test_latency();
        test_multiplier();
        test_priority();
        test_inactive();
        test_saturation();
        test_tie_high();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
